// File: rtl/spi_master.sv
// spi_master: mode-0 SPI initiator with a valid/ready word interface.
// Frames of several words keep negss low; sclk is divided down from clk.
module spi_master #(
   parameter int WIDTH   = 8,
   parameter int CLK_DIV = 4
) (
   input  logic             clk,
   input  logic             negrst,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   input  logic             tx_last,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             busy,
   output logic             sclk,
   output logic             mosi,
   input  logic             miso,
   output logic             negss
);

   localparam int CW = $clog2(CLK_DIV + 1);
   localparam int BW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE, SETUP, HIGH, LOW, HOLD, END, GAP
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [BW-1:0]    bitcnt;
   logic [WIDTH-2:0] txsh;
   logic [WIDTH-1:0] rxsh;
   logic             last;
   logic             accept;
   logic             div_done;
   logic             last_bit;

   assign accept   = tx_valid & tx_ready;
   assign div_done = (cnt == CW'(CLK_DIV));
   assign last_bit = (bitcnt == BW'(WIDTH));

   // Sequencer: every phase lasts CLK_DIV cycles, all outputs registered.
   always_ff @(posedge clk or negedge negrst) begin
      if (!negrst) begin
         state    <= IDLE;
         cnt      <= '0;
         bitcnt   <= '0;
         txsh     <= '0;
         rxsh     <= '0;
         last     <= 1'b0;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         negss    <= 1'b1;
         tx_ready <= 1'b1;
         rx_valid <= 1'b0;
         rx_data  <= '0;
         busy     <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         case (state)
            IDLE, HOLD: begin
               if (accept) begin
                  txsh     <= tx_data[WIDTH-2:0];
                  last     <= tx_last;
                  mosi     <= tx_data[WIDTH-1];
                  negss    <= 1'b0;
                  sclk     <= 1'b0;
                  tx_ready <= 1'b0;
                  busy     <= 1'b1;
                  bitcnt   <= '0;
                  cnt      <= CW'(1);
                  state    <= SETUP;
               end
            end
            SETUP, LOW: begin
               if (div_done) begin
                  sclk   <= 1'b1;
                  rxsh   <= {rxsh[WIDTH-2:0], miso};
                  bitcnt <= bitcnt + BW'(1);
                  cnt    <= CW'(1);
                  state  <= HIGH;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            HIGH: begin
               if (div_done) begin
                  sclk <= 1'b0;
                  cnt  <= CW'(1);
                  if (last_bit) begin
                     rx_data  <= rxsh;
                     rx_valid <= 1'b1;
                     if (last) begin
                        state <= END;
                     end else begin
                        tx_ready <= 1'b1;
                        state    <= HOLD;
                     end
                  end else begin
                     mosi  <= txsh[WIDTH-2];
                     txsh  <= txsh << 1;
                     state <= LOW;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            END: begin
               if (div_done) begin
                  negss <= 1'b1;
                  cnt   <= CW'(1);
                  state <= GAP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            GAP: begin
               if (div_done) begin
                  tx_ready <= 1'b1;
                  busy     <= 1'b0;
                  cnt      <= '0;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed vectors and corner sequences for spi_master.
// A behavioural SPI peripheral answers with a fixed word or adder+25.
module tb_spi_master;

   logic       clk = 1'b0;
   logic       negrst = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       tx_last = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       sclk;
   logic       mosi;
   logic       miso = 1'b0;
   logic       negss;

   logic [7:0] tx_data1 = '0;
   logic       tx_valid1 = 1'b0;
   logic       tx_last1 = 1'b0;
   logic       tx_ready1;
   logic [7:0] rx_data1;
   logic       rx_valid1;
   logic       busy1;
   logic       sclk1;
   logic       mosi1;
   logic       negss1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] tx;
      logic [7:0] ret;
      logic [7:0] exp_rx;
      int         exp_rxv;
      int         exp_ss;
      int         exp_rdy;
      int         exp_r1;
      int         exp_r8;
   } vec_t;

   vec_t vecs[4];

   spi_master #(.WIDTH(8), .CLK_DIV(4)) dut (
      .clk(clk), .negrst(negrst), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
      .sclk(sclk), .mosi(mosi), .miso(miso), .negss(negss)
   );

   spi_master #(.WIDTH(8), .CLK_DIV(1)) dut1 (
      .clk(clk), .negrst(negrst), .tx_data(tx_data1),
      .tx_valid(tx_valid1), .tx_last(tx_last1), .tx_ready(tx_ready1),
      .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1),
      .sclk(sclk1), .mosi(mosi1), .miso(1'b1), .negss(negss1)
   );

   always #5 clk = ~clk;

   // cycle counter; acc marks the cycle 0 of the latest accept
   int cyc = 0;
   int acc = 0;
   int acc_q[$];
   always @(posedge clk) begin
      if (tx_valid && tx_ready) begin
         acc = cyc;
         acc_q.push_back(cyc);
      end
      cyc = cyc + 1;
   end

   // event log, sampled mid-cycle, relative to the latest accept
   int   rel;
   int   rise_q[$];
   int   rxvc_q[$];
   int   ssh_q[$];
   int   rdyc_q[$];
   logic [7:0] rx_q[$];
   logic sclk_q = 1'b0;
   logic ss_q = 1'b1;
   logic rdy_q = 1'b1;
   always @(negedge clk) begin
      rel = cyc - acc;
      if (sclk && !sclk_q) rise_q.push_back(rel);
      if (rx_valid) begin
         rx_q.push_back(rx_data);
         rxvc_q.push_back(rel);
      end
      if (negss && !ss_q) ssh_q.push_back(rel);
      if (tx_ready && !rdy_q) rdyc_q.push_back(rel);
      sclk_q = sclk;
      ss_q   = negss;
      rdy_q  = tx_ready;
   end

   // peripheral: mode 0, miso changes after falling sclk
   int         pmode = 0;
   logic [7:0] pret = 8'h3C;
   logic [7:0] pin = '0;
   logic [7:0] pout = '0;
   logic [7:0] plast = '0;
   int         pbit = 0;
   logic       p_sclk = 1'b0;
   logic       mbit_q[$];
   int         ss_bad = 0;
   always @(negedge negss or posedge sclk or negedge sclk) begin
      if (sclk) begin
         pin = {pin[6:0], mosi};
         mbit_q.push_back(mosi);
         pbit = pbit + 1;
         if (negss) ss_bad = ss_bad + 1;
      end else if (p_sclk) begin
         if (pbit >= 8) begin
            plast = pin;
            pbit  = 0;
            pout  = (pmode == 1) ? plast + 8'd25 : pret;
         end else begin
            pout = pout << 1;
         end
         miso = pout[7];
      end else begin
         pbit = 0;
         pout = (pmode == 1) ? plast + 8'd25 : pret;
         miso = pout[7];
      end
      p_sclk = sclk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  name, act, act, exp, exp);
      end
   endtask

   function automatic logic [7:0] word_at(input int b);
      logic [7:0] w;
      w = '0;
      for (int i = 0; i < 8; i++) begin
         w = {w[6:0], (b + i < mbit_q.size()) ? mbit_q[b + i] : 1'b0};
      end
      return w;
   endfunction

   function automatic int qat(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   // called at a negedge; returns at the negedge of cycle 1
   task automatic send(input logic [7:0] d, input logic l, input string nm);
      int n;
      n = 0;
      tx_data  = d;
      tx_valid = 1'b1;
      tx_last  = l;
      while (!tx_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!tx_ready) begin
         failures++;
         $display("FAIL %s_accept: tx_ready 0 after %0d cycles", nm, n);
      end
      @(posedge clk);
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while ((busy || !tx_ready) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy || !tx_ready) begin
         failures++;
         $display("FAIL %s_idle: busy=%0b tx_ready=%0b after %0d cycles",
                  nm, busy, tx_ready, n);
      end
      @(negedge clk);
   endtask

   task automatic apply(input vec_t v, input string tag);
      int bm, br, bx, bv, bs, bd, bad;
      pmode = 0;
      pret  = v.ret;
      bm = mbit_q.size();
      br = rise_q.size();
      bx = rx_q.size();
      bv = rxvc_q.size();
      bs = ssh_q.size();
      bd = rdyc_q.size();
      send(v.tx, 1'b1, tag);
      wait_idle(tag);
      chk({tag, "_mosi"}, int'(word_at(bm)), int'(v.tx));
      chk({tag, "_nrx"}, rx_q.size() - bx, 1);
      chk({tag, "_rx"}, (rx_q.size() > bx) ? int'(rx_q[bx]) : -1,
          int'(v.exp_rx));
      chk({tag, "_rxv_cyc"}, qat(rxvc_q, bv), v.exp_rxv);
      chk({tag, "_ss_hi_cyc"}, qat(ssh_q, bs), v.exp_ss);
      chk({tag, "_rdy_cyc"}, qat(rdyc_q, bd), v.exp_rdy);
      chk({tag, "_nrise"}, rise_q.size() - br, 8);
      chk({tag, "_rise1"}, qat(rise_q, br), v.exp_r1);
      chk({tag, "_rise8"}, qat(rise_q, br + 7), v.exp_r8);
      bad = 0;
      for (int k = 1; k < 8; k++) begin
         if (qat(rise_q, br + k) - qat(rise_q, br + k - 1) != 8) bad++;
      end
      chk({tag, "_rise_spacing"}, bad, 0);
   endtask

   initial begin
      int bm, br, bx, bs, bd, ba, bb, n, c, rv, sh, rises, mlow;
      logic [7:0] rxd;
      logic s1q, ss_lo1, rdy_c1;

      vecs[0] = '{8'hA5, 8'h3C, 8'h3C, 65, 69, 73, 5, 61};
      vecs[1] = '{8'h00, 8'hFF, 8'hFF, 65, 69, 73, 5, 61};
      vecs[2] = '{8'hFF, 8'h00, 8'h00, 65, 69, 73, 5, 61};
      vecs[3] = '{8'h81, 8'h7E, 8'h7E, 65, 69, 73, 5, 61};

      @(negedge clk);
      chk("reset_outputs",
          int'({sclk, mosi, negss, tx_ready, rx_valid, busy, rx_data}),
          int'({1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00}));
      repeat (2) @(negedge clk);
      negrst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         apply(vecs[i], $sformatf("vec%0d", i));
      end

      // adder frame: three words, negss held low
      pmode = 1;
      plast = 8'h00;
      bm = mbit_q.size();
      br = rise_q.size();
      bx = rx_q.size();
      bs = ssh_q.size();
      bb = ss_bad;
      send(8'h00, 1'b0, "add0");
      send(8'h0A, 1'b0, "add1");
      send(8'h00, 1'b1, "add2");
      wait_idle("adder");
      chk("adder_nrx", rx_q.size() - bx, 3);
      chk("adder_rx2", (rx_q.size() > bx + 1) ? int'(rx_q[bx + 1]) : -1,
          8'h19);
      chk("adder_rx3", (rx_q.size() > bx + 2) ? int'(rx_q[bx + 2]) : -1,
          8'h23);
      chk("adder_nrise", rise_q.size() - br, 24);
      chk("adder_ss_rises", ssh_q.size() - bs, 1);
      chk("adder_ss_low_at_rise", ss_bad - bb, 0);
      chk("adder_mosi2", int'(word_at(bm + 8)), 8'h0A);

      // back-pressure: tx_valid held, tx_data churns during transfer
      pmode = 0;
      pret  = 8'h66;
      bm = mbit_q.size();
      ba = acc_q.size();
      tx_data  = 8'h81;
      tx_valid = 1'b1;
      tx_last  = 1'b1;
      n = 0;
      for (int cc = 1; cc <= 72; cc++) begin
         @(negedge clk);
         if (tx_ready) n++;
         tx_data = 8'($urandom);
      end
      chk("bp_ready_low", n, 0);
      @(negedge clk);
      chk("bp_ready_c73", int'(tx_ready), 1);
      tx_data = 8'h5A;
      @(posedge clk);
      @(negedge clk);
      tx_valid = 1'b0;
      chk("bp_naccept", acc_q.size() - ba, 2);
      chk("bp_accept_gap",
          (acc_q.size() >= ba + 2) ? acc_q[ba + 1] - acc_q[ba] : -1, 73);
      wait_idle("bp");
      chk("bp_mosi1", int'(word_at(bm)), 8'h81);
      chk("bp_mosi2", int'(word_at(bm + 8)), 8'h5A);

      // async reset in the 3rd HIGH phase, then a clean transfer
      pret = 8'h3C;
      br = rise_q.size();
      bx = rx_q.size();
      send(8'hC3, 1'b1, "rst");
      n = 0;
      while (rise_q.size() < br + 3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("rst_reach_rise3", rise_q.size() - br, 3);
      chk("rst_sclk_high_before", int'(sclk), 1);
      #2 negrst = 1'b0;
      #1;
      chk("rst_sclk", int'(sclk), 0);
      chk("rst_negss", int'(negss), 1);
      chk("rst_mosi", int'(mosi), 0);
      chk("rst_tx_ready", int'(tx_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_rx_data", int'(rx_data), 0);
      chk("rst_rx_valid", int'(rx_valid), 0);
      repeat (3) @(negedge clk);
      chk("rst_no_rxv", rx_q.size() - bx, 0);
      negrst = 1'b1;
      @(negedge clk);
      apply('{8'h55, 8'hAA, 8'hAA, 65, 69, 73, 5, 61}, "post_rst");

      // CLK_DIV=1 instance, miso tied high
      tx_data1  = 8'hFF;
      tx_valid1 = 1'b1;
      tx_last1  = 1'b1;
      rdy_c1    = tx_ready1;
      @(posedge clk);
      @(negedge clk);
      tx_valid1 = 1'b0;
      ss_lo1 = negss1;
      c = 1;
      rv = -1;
      sh = -1;
      rxd = '0;
      rises = 0;
      mlow = 0;
      s1q = sclk1;
      while (c < 40) begin
         if (rx_valid1 && rv < 0) begin
            rv  = c;
            rxd = rx_data1;
         end
         if (negss1 && sh < 0) sh = c;
         if (!negss1 && !mosi1) mlow++;
         if (sclk1 && !s1q) rises++;
         s1q = sclk1;
         @(negedge clk);
         c++;
      end
      chk("div1_ready_before", int'(rdy_c1), 1);
      chk("div1_negss_c1", int'(ss_lo1), 0);
      chk("div1_rxv_cyc", rv, 17);
      chk("div1_rx", int'(rxd), 8'hFF);
      chk("div1_ss_hi_cyc", sh, 18);
      chk("div1_nrise", rises, 8);
      chk("div1_mosi", mlow, 0);
      chk("div1_idle", int'({busy1, tx_ready1}), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
